// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// parity selections understood by the transmitter, and a width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } arb_state_t;

    localparam logic [1:0] TX_PARITY_NONE = 2'd0;
    localparam logic [1:0] TX_PARITY_EVEN = 2'd1;
    localparam logic [1:0] TX_PARITY_ODD  = 2'd2;

    // Bits needed to hold 'value' distinct codes, never less than one bit.
    function automatic int clog2_safe(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and transmitter handshake bundle around the arbiter.
// master: the arbiter itself; slave: the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_din;
    logic                          tx_done;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ack, tx_start, tx_din
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ack, tx_start, tx_din
    );
endinterface

// File: rtl/uart_rr_grant.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, wrapping around to index 0.
module uart_rr_grant #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any_req,
    output logic [$clog2(NUM_REQ)-1:0] win_id,
    output logic [NUM_REQ-1:0]         win_onehot
);
    localparam int ID_W = $clog2(NUM_REQ);

    int unsigned idx;

    // Scan requesters in priority order starting at the pointer.
    always_comb begin
        any_req    = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
        if (any_req) begin
            win_onehot[win_id] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources. Each frame: grant
// round-robin, hand the byte to tx, wait for completion under a watchdog,
// then hold off for an inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sample_tick,
    uart_tx_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = clog2_safe(CNT_MAX + 1);

    arb_state_t            state;
    logic [CNT_W-1:0]      tick_cnt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       next_ptr;
    logic [ID_W-1:0]       win_id;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] win_byte;

    uart_rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .req_valid  (bus.req_valid),
        .ptr        (rr_ptr),
        .any_req    (any_req),
        .win_id     (win_id),
        .win_onehot (win_onehot)
    );

    assign win_byte = bus.req_data[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Arbiter FSM: grant, watch for completion or stall, then enforce the gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            rr_ptr      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            bus.req_ack  <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_din   <= '0;
        end else begin
            bus.req_ack  <= '0;
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        bus.tx_din   <= win_byte;
                        bus.req_ack  <= win_onehot;
                        bus.tx_start <= 1'b1;
                        grant_id     <= win_id;
                        busy         <= 1'b1;
                        state        <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Completion takes priority over an expiring watchdog.
                    if (bus.tx_done) begin
                        rr_ptr   <= next_ptr;
                        tick_cnt <= '0;
                        if (GAP_TICKS == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tick_cnt == CNT_W'(TIMEOUT_TICKS)) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        tick_cnt    <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else if (sample_tick) begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (tick_cnt == CNT_W'(GAP_TICKS)) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (sample_tick) begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a stub transmitter.
module tb_uart_tx_arbiter;
    localparam int NR        = 4;
    localparam int DW        = 8;
    localparam int GAP       = 16;
    localparam int TMO       = 256;
    localparam int TICK_DIV  = 4;
    localparam int FRAME_CYC = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          sample_tick = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .DATA_WIDTH    (DW),
        .GAP_TICKS     (GAP),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample_tick (sample_tick),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         model_ptr = 0;
    int         tick_ctr = 0;
    bit         hold_mode = 0;
    int         hold_acks = 0;
    bit         stall = 0;
    bit         tx_busy = 0;
    int         tx_left = 0;
    bit         in_gap = 0;
    bit         gap_pend = 0;
    int         gap_cnt = 0;
    logic [7:0] last_byte = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: each pending requester is served once, in round-robin order
    // from the current pointer; the pointer then moves past the winner.
    task automatic model_grants(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data);
        logic [NR-1:0] rem;
        exp_t          e;
        bit            found;
        rem = mask;
        while (rem != '0) begin
            found = 0;
            for (int k = 0; k < NR; k++) begin
                int id;
                id = (model_ptr + k) % NR;
                if (!found && rem[id]) begin
                    found = 1;
                    e.id = id;
                    e.data = data[id*DW +: DW];
                    exp_q.push_back(e);
                    rem[id] = 1'b0;
                    model_ptr = (id + 1) % NR;
                end
            end
        end
    endtask

    // One clock: requesters react to acks, stub tx runs, gap timing is tracked.
    task automatic step();
        logic tick_d;
        logic done_d;
        tick_d = sample_tick;
        done_d = bus.tx_done;
        @(posedge clk);
        #1;
        if (!rst) begin
            in_gap = 0;
            gap_pend = 0;
            tx_busy = 0;
            bus.tx_done = 1'b0;
        end else begin
            if (gap_pend) begin
                chk("gap_end_busy", busy, 0);
                gap_pend = 0;
            end
            if (done_d) begin
                in_gap = 1;
                gap_cnt = 0;
            end else if (in_gap && tick_d) begin
                gap_cnt++;
                if (gap_cnt == GAP) begin
                    chk("gap_hold_busy", busy, 1);
                    gap_pend = 1;
                    in_gap = 0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ack[i]) begin
                    if (hold_mode) begin
                        hold_acks++;
                        if (hold_acks == 5) bus.req_valid = '0;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.tx_done = 1'b0;
            if (tx_busy) begin
                if (tx_left == 0) begin
                    bus.tx_done = 1'b1;
                    tx_busy = 0;
                end else begin
                    tx_left--;
                end
            end
            if (bus.tx_start && !stall) begin
                tx_busy = 1;
                tx_left = FRAME_CYC;
            end
        end
        tick_ctr++;
        sample_tick = ((tick_ctr % TICK_DIV) == 0);
    endtask

    task automatic wait_start(input int limit, input string name);
        int n;
        n = 0;
        while (!bus.tx_start && n < limit) begin
            step();
            n++;
        end
        chk(name, 32'(bus.tx_start), 1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(busy == 1'b0 && bus.req_valid == '0 && exp_q.size() == 0 && !tx_busy) && n < limit) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(n < limit), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        hold_mode = 0;
        stall = 0;
        step();
        step();
        rst = 1'b1;
        model_ptr = 0;
    endtask

    task automatic run_round(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data);
        model_grants(mask, data);
        bus.req_data = data;
        bus.req_valid = mask;
        wait_idle(2000);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ack"}, 32'(bus.req_ack), 0);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        chk({tag, "_tx_din"}, 32'(bus.tx_din), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Monitor: every frame start is checked against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.tx_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got id %0d byte %0h, expected no frame", grant_id, bus.tx_din);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("grant_id", 32'(grant_id), 32'(e.id));
                        chk("tx_din", 32'(bus.tx_din), 32'(e.data));
                        chk("req_ack", 32'(bus.req_ack), 32'(1) << e.id);
                        last_byte = e.data;
                    end
                end else if (bus.req_ack != '0) begin
                    chk("stray_ack", 32'(bus.req_ack), 0);
                end
                if (bus.tx_done) begin
                    chk("din_hold", 32'(bus.tx_din), 32'(last_byte));
                end
            end
        end
    end

    initial begin
        logic [NR*DW-1:0] d;
        int               n;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_done   = 1'b0;
        en = 1'b1;

        do_reset();
        check_all_zero("reset");

        // Single request.
        d = '0;
        d[7:0] = 8'h5A;
        model_grants(4'b0001, d);
        bus.req_data = d;
        bus.req_valid = 4'b0001;
        step();
        chk("single_start_latency", 32'(bus.tx_start), 1);
        chk("single_busy", 32'(busy), 1);
        wait_idle(1000);
        chk("single_end_busy", 32'(busy), 0);

        // Contention with all requesters held valid.
        do_reset();
        d = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            bit   found;
            found = 0;
            for (int j = 0; j < NR; j++) begin
                int id;
                id = (model_ptr + j) % NR;
                if (!found) begin
                    found = 1;
                    e.id = id;
                    e.data = d[id*DW +: DW];
                    exp_q.push_back(e);
                    model_ptr = (id + 1) % NR;
                end
            end
        end
        hold_mode = 1;
        hold_acks = 0;
        bus.req_data = d;
        bus.req_valid = 4'b1111;
        wait_idle(3000);
        chk("hold_acks", 32'(hold_acks), 5);
        hold_mode = 0;

        // Pointer wrap: grant 2 leaves pointer at 3, then 0 before 2.
        do_reset();
        run_round(4'b0100, {$urandom, $urandom} >> 0);
        run_round(4'b0101, 32'($urandom));

        // Random rounds.
        for (int r = 0; r < 8; r++) begin
            run_round(4'($urandom_range(1, 15)), 32'($urandom));
        end

        // Enable gating.
        en = 1'b0;
        d = 32'($urandom);
        bus.req_data = d;
        bus.req_valid = 4'b0010;
        repeat (1000) step();
        chk("en_blocked_busy", 32'(busy), 0);
        chk("en_blocked_valid", 32'(bus.req_valid), 32'h2);
        model_grants(4'b0010, d);
        en = 1'b1;
        wait_start(2, "en_grant_latency");
        wait_idle(1000);

        // Watchdog: transmitter never completes.
        stall = 1;
        d = 32'($urandom);
        model_grants(4'(1 << $urandom_range(0, 3)), d);
        bus.req_data = d;
        bus.req_valid = 4'(1) << exp_q[0].id;
        wait_start(4, "wd_start");
        n = 0;
        for (int c = 0; c < 3000 && !timeout_err; c++) begin
            logic t;
            t = sample_tick;
            step();
            if (!timeout_err && t) n++;
        end
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_ticks", 32'(n), TMO);
        chk("timeout_idle", 32'(busy), 0);
        stall = 0;
        run_round(4'($urandom_range(1, 15)), 32'($urandom));
        chk("timeout_sticky", 32'(timeout_err), 1);

        // Reset mid-frame; pointer must return to 0.
        do_reset();
        run_round(4'b0100, 32'($urandom));
        d = 32'($urandom);
        model_grants(4'b1000, d);
        bus.req_data = d;
        bus.req_valid = 4'b1000;
        wait_start(4, "midrst_start");
        repeat (5) step();
        rst = 1'b0;
        step();
        check_all_zero("midrst");
        rst = 1'b1;
        model_ptr = 0;
        run_round(4'b1001, 32'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (`tx`) between NUM_REQ byte producers using round-robin arbitration.
- Per frame, it latches the granted byte, drives `tx_din`, and pulses `tx_start`.
- It then waits for `tx_done`, enforces a programmable inter-frame gap, and flags a watchdog timeout if the transmitter stalls.
- Sits between the application-side byte sources and `tx`, in the same `clk` / `sample_tick` domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, bits per byte; must match `tx`.
- GAP_TICKS, 16, idle `sample_tick`s inserted after each `tx_done`; 0 means no gap.
- TIMEOUT_TICKS, 256, `sample_tick`s allowed in WAIT_DONE before a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- en  in  1  grant enable; low blocks new grants but lets the current frame finish
- sample_tick  in  1  16x baud tick, shared with `tx`
- req_valid  in  NUM_REQ  per-requester byte-available flag
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; byte consumed
- tx_start  out  1  1-cycle start pulse to `tx`
- tx_din  out  DATA_WIDTH  byte to `tx`; held stable from grant until `tx_done`
- tx_done  in  1  1-cycle completion pulse from `tx`
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset:
  - One clock (`clk`); reset is synchronous and active-low (`rst` low, sampled on posedge `clk`).
  - Reset values: state=IDLE; `req_ack`=0, `tx_start`=0, `tx_din`=0, `grant_id`=0, `busy`=0, `timeout_err`=0; RR pointer=0; tick counter=0.
  - Reset asserted mid-frame aborts immediately with the same values. Resetting `tx` is the system's responsibility.
- All outputs are registered.
- IDLE:
  - Grant condition: `en`=1 and any `req_valid` bit set.
  - Winner: first set bit searching from RR pointer upward, with wrap-around.
  - Next edge: `tx_din`←winner's byte, `grant_id`←winner, `req_ack[winner]`=1, `tx_start`=1, state→WAIT_DONE.
  - `req_ack` and `tx_start` are therefore high for exactly one cycle, one cycle after the grant decision.
  - Requester handshake: hold `req_valid` and its data stable until `req_ack`. It may re-assert `req_valid` with a new byte in the same cycle `req_ack` is seen.
- WAIT_DONE:
  - Tick counter increments on each `sample_tick`.
  - On `tx_done`: RR pointer←(`grant_id`+1) mod NUM_REQ, counter←0, state→GAP, or →IDLE if GAP_TICKS=0.
  - Timeout: counter reaches TIMEOUT_TICKS with no `tx_done` in that cycle → `timeout_err`←1 (sticky until reset); pointer advances as for `tx_done`; state→IDLE.
  - `tx_done` and the timeout condition in the same cycle: `tx_done` wins and no error is raised.
  - `tx_done` arriving in IDLE or GAP is ignored.
- GAP:
  - Counter increments on `sample_tick`.
  - At count GAP_TICKS → counter←0, state→IDLE.
  - No grants are made in GAP.
- `en` is sampled only in IDLE; deasserting it in WAIT_DONE or GAP has no effect on the current frame.
- Minimum spacing is one `tx_done`-to-`tx_start` gap of GAP_TICKS ticks plus 2 `clk` cycles.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NUM_REQ-1,0,…
- Tick counter width: $clog2(max(GAP_TICKS, TIMEOUT_TICKS)+1).

Decomposition:
- uart_pkg holds:
  - arbiter state encoding: IDLE, WAIT_DONE, GAP
  - TX_PARITY_NONE/EVEN/ODD constants shared with `tx`
  - function clog2_safe
- Sub-module uart_rr_grant: combinational round-robin picker.
  - Inputs: `req_valid`, pointer.
  - Outputs: `any_req`, winner index, one-hot.

Test Plan:
- Single request: `req_valid`=0001, data 0x5A → after 1 cycle `tx_start`=1, `tx_din`=0x5A, `req_ack`=0001, `grant_id`=0. `tx` line emits 0x5A; after `tx_done` plus 16 ticks, `busy`=0.
- Contention: `req_valid`=1111 held, bytes 0x10/0x21/0x32/0x43 → frames in order 0x10,0x21,0x32,0x43,0x10; each `req_ack` bit pulses once per frame.
- Pointer wrap: pointer=3 after granting 2, `req_valid`=0101 → requester 0 granted, then requester 2.
- Watchdog: grant, then stub `tx_done` never asserts → after 256 ticks `timeout_err`=1 and state IDLE. A subsequent grant still works and `timeout_err` stays 1.
- `en` gating: `en`=0 with `req_valid`=0010 → no `tx_start` for 1000 cycles. Raise `en` → grant within 2 cycles.
- Reset mid-frame: `rst`=0 during WAIT_DONE → next cycle all outputs 0, pointer 0. Pending `req_valid`=1000 is granted after release.
